// File: rtl/pu_msp430_ram_pkg.sv
// pu_msp430_ram_pkg
// Shared types and elaboration-time helpers for the parametrised data RAM.
//   ram_state_e : controller state (sweep in progress / ready for accesses)
//   ram_lanes   : number of byte lanes for a given data width
//   ram_depth   : number of words for a given byte size and data width
//   ram_cfg_ok  : legality of a parameter set
package pu_msp430_ram_pkg;

  typedef enum logic [0:0] {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

  function automatic int ram_lanes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int ram_depth(input int mem_size, input int data_width);
    return mem_size / (data_width / 8);
  endfunction

  // At least two words keeps the sweep pointer at least one bit wide.
  function automatic bit ram_cfg_ok(input int addr_msb, input int mem_size,
                                    input int data_width);
    return (data_width >= 8) && (data_width % 8 == 0) &&
           (ram_depth(mem_size, data_width) >= 2) &&
           (ram_depth(mem_size, data_width) <= (1 << (addr_msb + 1)));
  endfunction

endpackage

// File: rtl/pu_msp430_ram_clr_fsm.sv
// pu_msp430_ram_clr_fsm
// Clear-on-reset sweep controller for the data RAM.
//   state     | meaning
//   ----------+------------------------------------------------------
//   RAM_CLEAR | writing the fill value to word[ptr], one word per cycle
//   RAM_READY | sweep finished, user port owns the array
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset
//   busy     : sweep in progress (also high while rst is asserted)
//   clr_we   : sweep write strobe for this cycle
//   clr_addr : word address written by the sweep
module pu_msp430_ram_clr_fsm
  import pu_msp430_ram_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int AW         = 7,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam ram_state_e    RST_STATE = CLR_ON_RST ? RAM_CLEAR : RAM_READY;

  ram_state_e    state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RST_STATE;
      ptr    <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      // busy drops on the same edge that writes the last word
      busy_q <= (state_nxt == RAM_CLEAR);
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_we    = 1'b0;
    case (state)
      RAM_CLEAR: begin
        clr_we = ~rst;
        if (ptr == LAST) begin
          state_nxt = RAM_READY;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      RAM_READY: begin
        state_nxt = RAM_READY;
      end
      default: begin
        state_nxt = RST_STATE;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign clr_addr = ptr;
  assign busy     = busy_q | rst;

endmodule

// File: rtl/pu_msp430_ram_clr.sv
// pu_msp430_ram_clr
// Single-port data/program RAM with per-byte active-low write enables,
// write-first read data, optional output register, clear-on-reset sweep
// and out-of-range access detection.
// Ports:
//   ram_clk      : clock
//   ram_rst      : synchronous active-high reset
//   ram_addr     : word address
//   ram_cen      : chip enable, active low
//   ram_din      : write data
//   ram_wen      : per-lane write enable, active low
//   ram_dout     : read data (holds the last returned word)
//   ram_dout_vld : one-cycle pulse, ram_dout carries a new result
//   ram_busy     : clear sweep in progress, accesses ignored
//   ram_err      : one-cycle pulse, out-of-range access
module pu_msp430_ram_clr
  import pu_msp430_ram_pkg::*;
#(
  parameter int                    ADDR_MSB   = 6,
  parameter int                    MEM_SIZE   = 256,
  parameter int                    DATA_WIDTH = 16,
  parameter bit                    OUT_REG    = 1'b0,
  parameter bit                    CLR_ON_RST = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                  ram_clk,
  input  logic                  ram_rst,
  input  logic [ADDR_MSB:0]     ram_addr,
  input  logic                  ram_cen,
  input  logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH/8-1:0] ram_wen,
  output logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_dout_vld,
  output logic                  ram_busy,
  output logic                  ram_err
);

  localparam int NB    = ram_lanes(DATA_WIDTH);
  localparam int DEPTH = ram_depth(MEM_SIZE, DATA_WIDTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int AWID  = ADDR_MSB + 1;
  // one extra bit so DEPTH == 2**AWID is still representable
  localparam logic [AWID:0] DEPTH_W = (AWID + 1)'(DEPTH);

  if (!ram_cfg_ok(ADDR_MSB, MEM_SIZE, DATA_WIDTH)) begin : g_bad_cfg
    $error("pu_msp430_ram_clr: illegal DATA_WIDTH/MEM_SIZE/ADDR_MSB combination");
  end

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  pu_msp430_ram_clr_fsm #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_fsm (
    .clk      (ram_clk),
    .rst      (ram_rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic                  acc;
  logic                  in_range;
  logic                  acc_ok;
  logic [AW-1:0]         idx;
  logic [DATA_WIDTH-1:0] word_new;

  assign acc      = ~busy & ~ram_cen;
  assign in_range = ({1'b0, ram_addr} < DEPTH_W);
  assign acc_ok   = acc & in_range;
  assign idx      = ram_addr[AW-1:0];

  // Sweep and user port never write in the same cycle: user accesses are
  // gated off while busy is high.
  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge ram_clk) begin
      if (clr_we) begin
        mem[clr_addr] <= CLR_VALUE[8*g +: 8];
      end else if (acc_ok && !ram_wen[g]) begin
        mem[idx] <= ram_din[8*g +: 8];
      end
    end

    // write-first: the returned lane is the value the array will hold
    assign word_new[8*g +: 8] = ram_wen[g] ? mem[idx] : ram_din[8*g +: 8];
  end

  logic [DATA_WIDTH-1:0] dout_s1;
  logic                  vld_s1;
  logic                  err_s1;

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      dout_s1 <= '0;
      vld_s1  <= 1'b0;
      err_s1  <= 1'b0;
    end else begin
      vld_s1 <= acc_ok;
      err_s1 <= acc & ~in_range;
      if (acc_ok) begin
        dout_s1 <= word_new;
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout_s2;
    logic                  vld_s2;
    logic                  err_s2;

    always_ff @(posedge ram_clk) begin
      if (ram_rst) begin
        dout_s2 <= '0;
        vld_s2  <= 1'b0;
        err_s2  <= 1'b0;
      end else begin
        vld_s2 <= vld_s1;
        err_s2 <= err_s1;
        if (vld_s1) begin
          dout_s2 <= dout_s1;
        end
      end
    end

    assign ram_dout     = dout_s2;
    assign ram_dout_vld = vld_s2;
    assign ram_err      = err_s2;
  end else begin : g_no_out_reg
    assign ram_dout     = dout_s1;
    assign ram_dout_vld = vld_s1;
    assign ram_err      = err_s1;
  end

  assign ram_busy = busy;

endmodule

// File: tb/tb_pu_msp430_ram_clr.sv
module tb_pu_msp430_ram_clr;

  localparam int          ADDR_MSB = 7;
  localparam int          MEM_SIZE = 256;
  localparam int          DW       = 16;
  localparam int          DEPTH    = 128;
  localparam logic [15:0] CLRV     = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic [7:0]  addr = '0;
  logic [15:0] din = '0;
  logic [1:0]  wen = 2'b11;

  logic [15:0] dout0, dout1;
  logic        vld0, vld1, err0, err1, busy0, busy1;

  always #5 clk = ~clk;

  pu_msp430_ram_clr #(
    .ADDR_MSB(ADDR_MSB), .MEM_SIZE(MEM_SIZE), .DATA_WIDTH(DW),
    .OUT_REG(1'b0), .CLR_ON_RST(1'b1), .CLR_VALUE(CLRV)
  ) u0 (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_cen(cen),
    .ram_din(din), .ram_wen(wen), .ram_dout(dout0), .ram_dout_vld(vld0),
    .ram_busy(busy0), .ram_err(err0)
  );

  pu_msp430_ram_clr #(
    .ADDR_MSB(ADDR_MSB), .MEM_SIZE(MEM_SIZE), .DATA_WIDTH(DW),
    .OUT_REG(1'b1), .CLR_ON_RST(1'b1), .CLR_VALUE(CLRV)
  ) u1 (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_cen(cen),
    .ram_din(din), .ram_wen(wen), .ram_dout(dout1), .ram_dout_vld(vld1),
    .ram_busy(busy1), .ram_err(err1)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] din;
    logic [1:0]  wen;
    logic [15:0] exp;
    bit          exp_err;
  } vec_t;

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [15:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] last_dout [2];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic e,
                     input logic [15:0] d);
    exp_t x;
    if (v || e) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut%0d unexpected output: vld=%0b err=%0b dout=%0h, expected none (cycle %0d)",
                 k, v, e, d, cyc);
      end else begin
        if (k == 0) x = q0.pop_front();
        else        x = q1.pop_front();
        check($sformatf("dut%0d latency", k), cyc, x.cyc);
        check($sformatf("dut%0d err flag", k), {31'd0, e}, {31'd0, x.is_err});
        check($sformatf("dut%0d vld flag", k), {31'd0, v}, {31'd0, !x.is_err});
        if (x.is_err) begin
          check($sformatf("dut%0d dout hold on err", k), {16'd0, d}, {16'd0, last_dout[k]});
        end else begin
          check($sformatf("dut%0d data", k), {16'd0, d}, {16'd0, x.data});
          last_dout[k] = x.data;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst) begin
      mon(0, vld0, err0, dout0);
      mon(1, vld1, err1, dout1);
    end
  end

  task automatic wait_busy_low(output int edges);
    edges = 0;
    while (1) begin
      @(posedge clk);
      #1;
      edges++;
      if (!busy0 || edges >= 300) break;
    end
    check("dut1 busy tracks dut0", {31'd0, busy1}, {31'd0, busy0});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("scoreboard drained", q0.size() + q1.size(), 0);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    cen  = 1'b0;
    addr = v.addr;
    din  = v.din;
    wen  = v.wen;
    q0.push_back('{cyc + 1, v.exp_err, v.exp});
    q1.push_back('{cyc + 2, v.exp_err, v.exp});
  endtask

  task automatic idle();
    @(negedge clk);
    cen = 1'b1;
    wen = 2'b11;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  vec_t vecs[19];
  int   edges;

  initial begin
    last_dout[0] = '0;
    last_dout[1] = '0;
    vecs[0]  = '{8'd0,   16'hFFFF, 2'b11, CLRV,     1'b0};
    vecs[1]  = '{8'd64,  16'h0000, 2'b11, CLRV,     1'b0};
    vecs[2]  = '{8'd127, 16'h0000, 2'b11, CLRV,     1'b0};
    vecs[3]  = '{8'd5,   16'h1234, 2'b00, 16'h1234, 1'b0};
    vecs[4]  = '{8'd5,   16'hABCD, 2'b01, 16'hAB34, 1'b0};
    vecs[5]  = '{8'd5,   16'h0000, 2'b11, 16'hAB34, 1'b0};
    vecs[6]  = '{8'd5,   16'h00EF, 2'b10, 16'hABEF, 1'b0};
    vecs[7]  = '{8'd5,   16'hFFFF, 2'b11, 16'hABEF, 1'b0};
    vecs[8]  = '{8'd200, 16'hBEEF, 2'b00, 16'h0000, 1'b1};
    vecs[9]  = '{8'd72,  16'h0000, 2'b11, CLRV,     1'b0};
    vecs[10] = '{8'd1,   16'h1111, 2'b00, 16'h1111, 1'b0};
    vecs[11] = '{8'd2,   16'h2222, 2'b00, 16'h2222, 1'b0};
    vecs[12] = '{8'd3,   16'h3333, 2'b00, 16'h3333, 1'b0};
    vecs[13] = '{8'd1,   16'h0000, 2'b11, 16'h1111, 1'b0};
    vecs[14] = '{8'd2,   16'h0000, 2'b11, 16'h2222, 1'b0};
    vecs[15] = '{8'd3,   16'h0000, 2'b11, 16'h3333, 1'b0};
    vecs[16] = '{8'd9,   16'h5A5A, 2'b00, 16'h5A5A, 1'b0};
    vecs[17] = '{8'd9,   16'h0000, 2'b11, 16'h5A5A, 1'b0};
    vecs[18] = '{8'd250, 16'h0000, 2'b11, 16'h0000, 1'b1};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset dut0 dout", {16'd0, dout0}, 32'd0);
    check("reset dut1 dout", {16'd0, dout1}, 32'd0);
    check("reset dut0 vld/err", {30'd0, vld0, err0}, 32'd0);
    check("reset dut1 vld/err", {30'd0, vld1, err1}, 32'd0);
    check("reset dut0 busy", {31'd0, busy0}, 32'd1);
    check("reset dut1 busy", {31'd0, busy1}, 32'd1);

    // release reset with a write to word 0 held during the whole sweep
    @(negedge clk);
    rst  = 1'b0;
    cen  = 1'b0;
    addr = 8'd0;
    din  = 16'h1111;
    wen  = 2'b00;
    wait_busy_low(edges);
    check("sweep length", edges, DEPTH);

    foreach (vecs[i]) apply(vecs[i]);
    idle();
    drain();
    repeat (3) @(negedge clk);
    check("dut0 dout held when idle", {16'd0, dout0}, 32'h5A5A);
    check("dut1 dout held when idle", {16'd0, dout1}, 32'h5A5A);

    // reset in the middle of the sweep
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid-sweep reset dut0 dout", {16'd0, dout0}, 32'd0);
    check("mid-sweep reset dut1 dout", {16'd0, dout1}, 32'd0);
    last_dout[0] = '0;
    last_dout[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    wait_busy_low(edges);
    check("restarted sweep length", edges, DEPTH);

    // re-swept contents replace earlier writes
    apply('{8'd5, 16'h0000, 2'b11, CLRV, 1'b0});
    apply('{8'd9, 16'h0000, 2'b11, CLRV, 1'b0});
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
